out_txn_sequencer: RTL and testbench

//  Upstream control stage for the packet sender: runs one complete host OUT transaction.
//  Per attempt: send OUT token, send DATA0, then wait for the device handshake.

---
 rtl/usb_pkg.sv | 19 +
 rtl/txn_timeout_timer.sv | 31 +++
 rtl/out_txn_sequencer.sv | 151 +++++++++++++++
 tb/tb_out_txn_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared PID constants and host OUT transaction state encoding
package usb_pkg;

    typedef logic [3:0] pid_t;

    localparam pid_t PID_ACK   = 4'b0010;
    localparam pid_t PID_NAK   = 4'b1010;
    localparam pid_t PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TOKEN   = 3'd1,
        DATA    = 3'd2,
        WAIT_HS = 3'd3,
        RETRY   = 3'd4,
        DONE    = 3'd5
    } txn_state_t;

endpackage

// File: rtl/txn_timeout_timer.sv
// rtl/txn_timeout_timer.sv - handshake wait timer, expires on its TIMEOUT_CYC-th enabled cycle
module txn_timeout_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] count;

    // Count enabled cycles from zero; hold at the last value so a stalled consumer never sees a wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // The cycle whose count equals TIMEOUT_CYC-1 is the last one of the wait window.
    assign expired = en && (count == LAST);

endmodule

// File: rtl/out_txn_sequencer.sv
// rtl/out_txn_sequencer.sv - host OUT transaction sequencer (TOKEN, DATA0, handshake, retry); option TXN_STALL_ABORT_EN
module out_txn_sequencer
    import usb_pkg::*;
#(
    parameter int MAX_RETRY   = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        txn_start,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] txn_data,
    output logic        busy,
    output logic        txn_done,
    output logic        txn_success,
    output logic [3:0]  attempts,
    output logic        send_OUT,
    output logic        send_DATA0,
    output logic [3:0]  endp,
    output logic [63:0] data,
    input  logic        out_done,
    input  logic        rx_pid_valid,
    input  logic [3:0]  rx_pid,
    input  logic        rx_error
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    txn_state_t state;
    txn_state_t state_nxt;

    logic accept;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;
    logic hs_ack;
    logic hs_abort;
    logic hs_retry;

    assign accept    = (state == IDLE) && txn_start;
    assign timer_en  = (state == WAIT_HS);
    // Timer restarts as the DATA packet completes so WAIT_HS always starts from zero.
    assign timer_clr = (state == DATA) && out_done;

    txn_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Classify the handshake cycle; a decoded PID takes priority over error or timeout.
    always_comb begin
        hs_ack   = 1'b0;
        hs_abort = 1'b0;
        hs_retry = 1'b0;
        if (rx_pid_valid) begin
            if (rx_pid == PID_ACK) begin
                hs_ack = 1'b1;
`ifdef TXN_STALL_ABORT_EN
            end else if (rx_pid == PID_STALL) begin
                hs_abort = 1'b1;
`endif
            end else begin
                hs_retry = 1'b1;
            end
        end else if (rx_error || timer_expired) begin
            hs_retry = 1'b1;
        end
    end

    // Next-state decode for one transaction; stray inputs outside their states fall through.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (txn_start) state_nxt = TOKEN;
            TOKEN:   if (out_done)  state_nxt = DATA;
            DATA:    if (out_done)  state_nxt = WAIT_HS;
            WAIT_HS: begin
                if (hs_ack || hs_abort) begin
                    state_nxt = DONE;
                end else if (hs_retry) begin
                    state_nxt = RETRY;
                end
            end
            RETRY:   state_nxt = (attempts >= RETRY_LIMIT) ? DONE : TOKEN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any transaction without a txn_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sender strobes fire once, in the first cycle of TOKEN or DATA.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            send_OUT   <= 1'b0;
            send_DATA0 <= 1'b0;
        end else begin
            send_OUT   <= (state_nxt == TOKEN) && (state != TOKEN);
            send_DATA0 <= (state_nxt == DATA)  && (state != DATA);
        end
    end

    // Endpoint and payload are captured on accept and stay put for every retry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            endp <= '0;
            data <= '0;
        end else if (accept) begin
            endp <= txn_endp;
            data <= txn_data;
        end
    end

    // Attempt counter: cleared on accept, bumped in the first TOKEN cycle (marked by send_OUT).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            attempts <= '0;
        end else if (accept) begin
            attempts <= '0;
        end else if ((state == TOKEN) && send_OUT) begin
            attempts <= attempts + 4'd1;
        end
    end

    // Outcome flag: only an ACK handshake marks success; retry exhaustion or STALL leave it low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txn_success <= 1'b0;
        end else if (accept) begin
            txn_success <= 1'b0;
        end else if ((state == WAIT_HS) && (state_nxt == DONE)) begin
            txn_success <= hs_ack;
        end
    end

    assign busy     = (state != IDLE);
    assign txn_done = (state == DONE);

endmodule

// File: tb/tb_out_txn_sequencer.sv
// tb/tb_out_txn_sequencer.sv - self-checking bench for out_txn_sequencer with behavioural retry model
module tb_out_txn_sequencer;
    import usb_pkg::*;

    localparam int MAX_RETRY   = 8;
    localparam int TIMEOUT_CYC = 255;

    localparam int R_ACK   = 0;
    localparam int R_NAK   = 1;
    localparam int R_STALL = 2;
    localparam int R_ERR   = 3;
    localparam int R_OTHER = 4;
    localparam int R_NONE  = 5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        txn_start;
    logic [3:0]  txn_endp;
    logic [63:0] txn_data;
    logic        busy;
    logic        txn_done;
    logic        txn_success;
    logic [3:0]  attempts;
    logic        send_OUT;
    logic        send_DATA0;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        out_done;
    logic        rx_pid_valid;
    logic [3:0]  rx_pid;
    logic        rx_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Device behaviour per attempt: response kind and its delay into the handshake window
    int code [MAX_RETRY];
    int dly  [MAX_RETRY];

    always #5 clock = ~clock;

    out_txn_sequencer #(
        .MAX_RETRY   (MAX_RETRY),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .txn_start    (txn_start),
        .txn_endp     (txn_endp),
        .txn_data     (txn_data),
        .busy         (busy),
        .txn_done     (txn_done),
        .txn_success  (txn_success),
        .attempts     (attempts),
        .send_OUT     (send_OUT),
        .send_DATA0   (send_DATA0),
        .endp         (endp),
        .data         (data),
        .out_done     (out_done),
        .rx_pid_valid (rx_pid_valid),
        .rx_pid       (rx_pid),
        .rx_error     (rx_error)
    );

    function automatic void clear_script();
        for (int i = 0; i < MAX_RETRY; i++) begin
            code[i] = R_NONE;
            dly[i]  = 0;
        end
    endfunction

    // Outcome from the rules: first attempt answered in time by ACK (or STALL when aborting) ends it.
    function automatic void model(output bit succ, output int att);
        succ = 1'b0;
        att  = MAX_RETRY;
        for (int a = 0; a < MAX_RETRY; a++) begin
            if (code[a] == R_ACK && dly[a] <= TIMEOUT_CYC - 1) begin
                succ = 1'b1;
                att  = a + 1;
                return;
            end
`ifdef TXN_STALL_ABORT_EN
            if (code[a] == R_STALL && dly[a] <= TIMEOUT_CYC - 1) begin
                att = a + 1;
                return;
            end
`endif
        end
    endfunction

    task automatic idle_inputs();
        txn_start    = 1'b0;
        out_done     = 1'b0;
        rx_pid_valid = 1'b0;
        rx_pid       = 4'd0;
        rx_error     = 1'b0;
    endtask

    // Plays sender and device for one transaction; reset_after>0 pulls reset inside attempt 1's wait.
    task automatic run_txn(input string name, input logic [3:0] e, input logic [63:0] d, input int reset_after);
        bit exp_succ;
        int exp_att;
        int n_out = 0, n_data = 0, att_idx = 0, od_cnt = 0, hs_cnt = 0, rst_cnt = 0;
        int ack_cyc = -10, done_cyc = -1;
        bit od_is_data = 1'b0, done_seen = 1'b0, stable_ok = 1'b1, aborted = 1'b0, quiet_ok = 1'b1;
        model(exp_succ, exp_att);
        txn_start = 1'b1;
        txn_endp  = e;
        txn_data  = d;
        @(negedge clock);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            txn_start    = 1'b0;
            out_done     = 1'b0;
            rx_pid_valid = 1'b0;
            rx_error     = 1'b0;
            rx_pid       = 4'($urandom);
            txn_endp     = 4'($urandom);
            txn_data     = {$urandom, $urandom};
            if (!busy || endp !== e || data !== d) stable_ok = 1'b0;
            if (txn_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
            if (cyc == 2) txn_start = 1'b1;
            if (send_OUT) begin
                n_out++;
                att_idx++;
                hs_cnt       = 0;
                od_cnt       = int'($urandom_range(1, 4));
                od_is_data   = 1'b0;
                rx_pid_valid = 1'b1;
                rx_pid       = PID_ACK;
            end
            if (send_DATA0) begin
                n_data++;
                od_cnt     = int'($urandom_range(1, 4));
                od_is_data = 1'b1;
                rx_error   = 1'b1;
            end
            if (hs_cnt > 0) begin
                hs_cnt--;
                if (hs_cnt == 0 && att_idx >= 1 && att_idx <= MAX_RETRY) begin
                    case (code[att_idx-1])
                        R_ACK:   begin rx_pid_valid = 1'b1; rx_pid = PID_ACK; ack_cyc = cyc; end
                        R_NAK:   begin rx_pid_valid = 1'b1; rx_pid = PID_NAK; end
                        R_STALL: begin rx_pid_valid = 1'b1; rx_pid = PID_STALL; end
                        R_OTHER: begin rx_pid_valid = 1'b1; rx_pid = 4'b0011; end
                        R_ERR:   rx_error = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (od_cnt > 0) begin
                od_cnt--;
                if (od_cnt == 0) begin
                    out_done = 1'b1;
                    if (od_is_data && att_idx >= 1 && att_idx <= MAX_RETRY) begin
                        if (code[att_idx-1] != R_NONE) hs_cnt = dly[att_idx-1] + 1;
                        if (reset_after > 0 && att_idx == 1) rst_cnt = reset_after;
                    end
                end
            end
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) begin
                    aborted = 1'b1;
                    break;
                end
            end
            @(negedge clock);
        end
        idle_inputs();

        if (aborted) begin
            reset_n = 1'b0;
            #1;
            n_checks++;
            if ({busy, txn_done, txn_success, attempts, send_OUT, send_DATA0, endp, data} !== '0)
                begin n_fail++; $display("FAIL %s reset_outputs: got busy=%0b done=%0b succ=%0b att=%0d out=%0b d0=%0b endp=%h data=%h required all 0",
                    name, busy, txn_done, txn_success, attempts, send_OUT, send_DATA0, endp, data); end
            repeat (3) @(negedge clock);
            reset_n = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clock);
                if (txn_done || busy || send_OUT || send_DATA0) quiet_ok = 1'b0;
            end
            n_checks++;
            if (quiet_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL %s post_reset_quiet: got activity after abort, required idle with no txn_done", name);
            end
        end else begin
            n_checks++;
            if (!done_seen) begin
                n_fail++;
                $display("FAIL %s done_timeout: got no txn_done within 4000 cycles, required txn_done", name);
            end else begin
                n_checks++;
                if (txn_success !== exp_succ) begin
                    n_fail++;
                    $display("FAIL %s success: got %0b required %0b", name, txn_success, exp_succ);
                end
                n_checks++;
                if (attempts !== 4'(exp_att)) begin
                    n_fail++;
                    $display("FAIL %s attempts: got %0d required %0d", name, attempts, exp_att);
                end
                n_checks++;
                if (n_out != exp_att || n_data != exp_att) begin
                    n_fail++;
                    $display("FAIL %s strobes: got send_OUT=%0d send_DATA0=%0d required %0d each", name, n_out, n_data, exp_att);
                end
                n_checks++;
                if (stable_ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_endp_data: got busy low or endp/data changed, required busy high and endp=%h data=%h", name, e, d);
                end
                if (exp_succ) begin
                    n_checks++;
                    if (done_cyc != ack_cyc + 1) begin
                        n_fail++;
                        $display("FAIL %s ack_latency: got txn_done at cycle %0d required %0d", name, done_cyc, ack_cyc + 1);
                    end
                end
                @(negedge clock);
                n_checks++;
                if (busy !== 1'b0 || txn_done !== 1'b0 || attempts !== 4'(exp_att)) begin
                    n_fail++;
                    $display("FAIL %s after_done: got busy=%0b done=%0b att=%0d required 0 0 %0d", name, busy, txn_done, attempts, exp_att);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        txn_endp = 4'd0;
        txn_data = 64'd0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, txn_done, txn_success, attempts, send_OUT, send_DATA0, endp, data} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%0b done=%0b att=%0d endp=%h data=%h required all 0", busy, txn_done, attempts, endp, data);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || send_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%0b send_OUT=%0b required 0 0", busy, send_OUT);
        end
    endtask

    task automatic test_single_ack();
        clear_script();
        code[0] = R_ACK; dly[0] = 10;
        run_txn("single_ack", 4'd4, 64'hDEADBEEF_CAFEF00D, 0);
    endtask

    task automatic test_nak_retry();
        clear_script();
        code[0] = R_NAK; dly[0] = 3;
        code[1] = R_NAK; dly[1] = 7;
        code[2] = R_ACK; dly[2] = 5;
        run_txn("nak_nak_ack", 4'd9, 64'h0123_4567_89AB_CDEF, 0);
    endtask

    task automatic test_timeout();
        clear_script();
        run_txn("all_timeout", 4'd2, 64'hA5A5_5A5A_0F0F_F0F0, 0);
    endtask

    task automatic test_boundaries();
        clear_script();
        code[0] = R_ACK; dly[0] = TIMEOUT_CYC - 1;
        run_txn("ack_on_timeout_cycle", 4'd1, 64'h1111_2222_3333_4444, 0);
        clear_script();
        code[0] = R_ERR; dly[0] = 4;
        code[1] = R_ACK; dly[1] = 0;
        run_txn("rx_error_retry", 4'd15, 64'hFFFF_0000_FFFF_0000, 0);
        clear_script();
        code[0] = R_OTHER; dly[0] = 2;
        code[1] = R_ACK;   dly[1] = 1;
        run_txn("other_pid_retry", 4'd6, 64'h5555_AAAA_5555_AAAA, 0);
    endtask

    task automatic test_stall();
        clear_script();
        code[0] = R_STALL; dly[0] = 6;
        code[1] = R_ACK;   dly[1] = 6;
        run_txn("stall_first", 4'd3, 64'hBEEF_BEEF_BEEF_BEEF, 0);
    endtask

    task automatic test_reset_mid();
        clear_script();
        code[0] = R_ACK; dly[0] = 100;
        run_txn("reset_in_wait_hs", 4'd7, 64'h7777_8888_9999_AAAA, 6);
        clear_script();
        code[0] = R_ACK; dly[0] = 2;
        run_txn("after_reset_accept", 4'd8, 64'hC0FF_EE00_1234_5678, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < MAX_RETRY; a++) begin
                code[a] = int'($urandom_range(0, 5));
                dly[a]  = ($urandom_range(0, 9) == 0) ? TIMEOUT_CYC - 1 : int'($urandom_range(0, 30));
            end
            run_txn($sformatf("random_%0d", t), 4'($urandom), {$urandom, $urandom}, 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_ack();
        test_nak_retry();
        test_timeout();
        test_boundaries();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
